// File: rtl/motoro3_hall_decoder.sv
// Hall-sensor front end for the three-phase motor: synchronizes and filters the
// hall lines, decodes 6-step position/direction, and measures step/revolution periods.
module motoro3_hall_decoder #(
    parameter int FILT_CYC  = 8,
    parameter int STALL_CYC = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hallA,
    input  logic        hallB,
    input  logic        hallC,
    output logic [3:0]  m3stepFb,
    output logic        m3stepValid,
    output logic        m3dirFb,
    output logic [24:0] m3periodFb,
    output logic        m3periodStb,
    output logic [24:0] m3revPeriodFb,
    output logic        m3revStb,
    output logic        m3stall,
    output logic        m3hallErr
);

    localparam logic [0:0]  ST_INIT   = 1'b0;
    localparam logic [0:0]  ST_TRACK  = 1'b1;
    localparam logic [7:0]  FILT_LIM  = 8'(FILT_CYC);
    localparam logic [24:0] STALL_LIM = 25'(STALL_CYC);
    localparam logic [24:0] REV_MAX   = {25{1'b1}};

    function automatic logic [3:0] code_step(input logic [2:0] c);
        case (c)
            3'b101:  return 4'd0;
            3'b100:  return 4'd1;
            3'b110:  return 4'd2;
            3'b010:  return 4'd3;
            3'b011:  return 4'd4;
            3'b001:  return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic code_legal(input logic [2:0] c);
        return (c != 3'b000) && (c != 3'b111);
    endfunction

    logic [2:0]  hall_m_q, hall_m_d, hall_s_q, hall_s_d;
    logic [2:0]  cand_q, cand_d, filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [0:0]  state_q, state_d;
    logic [24:0] step_cnt_q, step_cnt_d, rev_cnt_q, rev_cnt_d;
    logic        ref_q, ref_d, first_q, first_d;
    logic [3:0]  step_q, step_d;
    logic        valid_q, valid_d, dir_q, dir_d;
    logic [24:0] period_q, period_d, rev_q, rev_d;
    logic        per_stb_q, per_stb_d, rev_stb_q, rev_stb_d;
    logic        stall_q, stall_d, err_q, err_d;

    logic [3:0]  new_step_s;
    logic        new_legal_s, chg_s, fwd_s, bwd_s, ref_keep_s;
    logic [24:0] rev_inc_s;

    // Synchronizer and consecutive-sample filter.
    always_comb begin
        hall_m_d    = {hallA, hallB, hallC};
        hall_s_d    = hall_m_q;
        filt_prev_d = filt_q;
        if (hall_s_q != cand_q) begin
            cand_d = hall_s_q;
            fcnt_d = 8'd1;
        end else begin
            cand_d = cand_q;
            fcnt_d = (fcnt_q < FILT_LIM) ? fcnt_q + 8'd1 : fcnt_q;
        end
        filt_d = (fcnt_d == FILT_LIM) ? cand_d : filt_q;
    end

    // Position/direction decode, period measurement and error/stall detection.
    always_comb begin
        new_step_s  = code_step(filt_q);
        new_legal_s = code_legal(filt_q);
        chg_s       = (filt_q != filt_prev_q);
        fwd_s       = (step_q == 4'd5) ? (new_step_s == 4'd0) : (new_step_s == step_q + 4'd1);
        bwd_s       = (step_q == 4'd0) ? (new_step_s == 4'd5) : (new_step_s == step_q - 4'd1);
        rev_inc_s   = (rev_cnt_q == REV_MAX) ? rev_cnt_q : rev_cnt_q + 25'd1;
        ref_keep_s  = ref_q && !(!first_q && (fwd_s != dir_q));

        state_d    = state_q;
        step_cnt_d = (step_cnt_q >= STALL_LIM) ? step_cnt_q : step_cnt_q + 25'd1;
        rev_cnt_d  = rev_inc_s;
        ref_d      = ref_q;
        first_d    = first_q;
        step_d     = step_q;
        valid_d    = valid_q;
        dir_d      = dir_q;
        period_d   = period_q;
        rev_d      = rev_q;
        stall_d    = stall_q;
        per_stb_d  = 1'b0;
        rev_stb_d  = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (new_legal_s) begin
                    step_d     = new_step_s;
                    valid_d    = 1'b1;
                    step_cnt_d = 25'd0;
                    rev_cnt_d  = 25'd0;
                    first_d    = 1'b1;
                    ref_d      = 1'b0;
                    stall_d    = 1'b0;
                    state_d    = ST_TRACK;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_TRACK: begin
                if (chg_s) begin
                    step_cnt_d = 25'd0;
                    stall_d    = 1'b0;
                    if (!new_legal_s) begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        ref_d   = 1'b0;
                        state_d = ST_INIT;
                    end else if (fwd_s || bwd_s) begin
                        step_d  = new_step_s;
                        dir_d   = fwd_s;
                        first_d = 1'b0;
                        if (!stall_q && !first_q) begin
                            period_d  = step_cnt_q + 25'd1;
                            per_stb_d = 1'b1;
                        end else begin
                            per_stb_d = 1'b0;
                        end
                        // Step 0 entry either publishes a revolution or arms the reference.
                        if (new_step_s == 4'd0) begin
                            rev_cnt_d = 25'd0;
                            ref_d     = 1'b1;
                            if (ref_keep_s) begin
                                rev_d     = rev_inc_s;
                                rev_stb_d = 1'b1;
                            end else begin
                                rev_stb_d = 1'b0;
                            end
                        end else begin
                            ref_d = ref_keep_s;
                        end
                    end else begin
                        err_d   = 1'b1;
                        step_d  = new_step_s;
                        ref_d   = 1'b0;
                        first_d = 1'b1;
                    end
                end else if (step_cnt_d == STALL_LIM) begin
                    stall_d = 1'b1;
                    ref_d   = 1'b0;
                end else begin
                    stall_d = stall_q;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hall_m_q    <= 3'b000;
            hall_s_q    <= 3'b000;
            cand_q      <= 3'b000;
            fcnt_q      <= 8'd0;
            filt_q      <= 3'b000;
            filt_prev_q <= 3'b000;
            state_q     <= ST_INIT;
            step_cnt_q  <= 25'd0;
            rev_cnt_q   <= 25'd0;
            ref_q       <= 1'b0;
            first_q     <= 1'b0;
            step_q      <= 4'd0;
            valid_q     <= 1'b0;
            dir_q       <= 1'b0;
            period_q    <= 25'd0;
            rev_q       <= 25'd0;
            per_stb_q   <= 1'b0;
            rev_stb_q   <= 1'b0;
            stall_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            hall_m_q    <= hall_m_d;
            hall_s_q    <= hall_s_d;
            cand_q      <= cand_d;
            fcnt_q      <= fcnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            rev_cnt_q   <= rev_cnt_d;
            ref_q       <= ref_d;
            first_q     <= first_d;
            step_q      <= step_d;
            valid_q     <= valid_d;
            dir_q       <= dir_d;
            period_q    <= period_d;
            rev_q       <= rev_d;
            per_stb_q   <= per_stb_d;
            rev_stb_q   <= rev_stb_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
        end
    end

    assign m3stepFb      = step_q;
    assign m3stepValid   = valid_q;
    assign m3dirFb       = dir_q;
    assign m3periodFb    = period_q;
    assign m3periodStb   = per_stb_q;
    assign m3revPeriodFb = rev_q;
    assign m3revStb      = rev_stb_q;
    assign m3stall       = stall_q;
    assign m3hallErr     = err_q;

endmodule

// File: tb/tb_motoro3_hall_decoder.sv
// Scoreboard bench for motoro3_hall_decoder: stimulus drives hall codes and queues
// the expected strobes from a timing-level model; a monitor pops and compares them.
module tb_motoro3_hall_decoder;

    localparam int FILT  = 8;
    localparam int STALL = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hallA = 1'b0, hallB = 1'b0, hallC = 1'b0;
    logic [3:0]  m3stepFb;
    logic        m3stepValid, m3dirFb, m3periodStb, m3revStb, m3stall, m3hallErr;
    logic [24:0] m3periodFb, m3revPeriodFb;

    motoro3_hall_decoder #(.FILT_CYC(FILT), .STALL_CYC(STALL)) dut (
        .clk(clk), .rst(rst), .hallA(hallA), .hallB(hallB), .hallC(hallC),
        .m3stepFb(m3stepFb), .m3stepValid(m3stepValid), .m3dirFb(m3dirFb),
        .m3periodFb(m3periodFb), .m3periodStb(m3periodStb),
        .m3revPeriodFb(m3revPeriodFb), .m3revStb(m3revStb),
        .m3stall(m3stall), .m3hallErr(m3hallErr)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int val; } ev_t;   // kind 0 period, 1 revolution, 2 hall error
    ev_t expq[$];
    int n_chk = 0, n_fail = 0;

    logic [2:0] lut [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    // Reference model state, in steps and absolute cycle times.
    bit mtrack, mvalid, mdir, mfirst, mref;
    int mstep, tlast, tref;
    logic [2:0] mf, cur;

    function automatic int step_of(logic [2:0] c);
        for (int i = 0; i < 6; i++) if (lut[i] == c) return i;
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(int k, int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        expq.push_back(e);
    endtask

    task automatic mon(int k, int v);
        ev_t e;
        if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d value %0d expected none (cycle %0d)", k, v, cyc);
        end else begin
            e = expq.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_value", v, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m3periodStb) mon(0, int'(m3periodFb));
            if (m3revStb)    mon(1, int'(m3revPeriodFb));
            if (m3hallErr)   mon(2, 0);
        end
    end

    task automatic model_reset();
        mtrack = 0; mvalid = 0; mdir = 0; mfirst = 0; mref = 0;
        mstep = 0; tlast = 0; tref = 0; mf = 3'b000;
    endtask

    task automatic model_change(logic [2:0] c, int t);
        int s, d, dt;
        bit stalled, nd;
        s       = step_of(c);
        dt      = t - tlast;
        stalled = mtrack && (dt > STALL);
        if (!mtrack) begin
            if (s >= 0) begin
                mtrack = 1; mvalid = 1; mstep = s; mfirst = 1; mref = 0; tlast = t;
            end
        end else begin
            tlast = t;
            if (s < 0) begin
                push(2, 0);
                mvalid = 0; mtrack = 0; mref = 0;
            end else begin
                d = (s - mstep + 6) % 6;
                if (d == 1 || d == 5) begin
                    nd = (d == 1);
                    if (!stalled && !mfirst) push(0, dt);
                    if (stalled || (!mfirst && nd != mdir)) mref = 0;
                    mdir   = nd;
                    mfirst = 0;
                    if (s == 0) begin
                        if (mref) push(1, t - tref);
                        tref = t;
                        mref = 1;
                    end
                end else begin
                    push(2, 0);
                    mref   = 0;
                    mfirst = 1;
                end
                mstep = s;
            end
        end
        mf = c;
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hall(logic [2:0] c);
        {hallA, hallB, hallC} = c;
    endtask

    task automatic apply(logic [2:0] c, int dwell, bit glitch);
        bit acc;
        int len;
        logic [2:0] gc;
        acc = (c != mf);
        set_hall(c);
        cur = c;
        if (acc) model_change(c, cyc);
        if (glitch && dwell >= 60) begin
            len = $urandom_range(1, 5);
            gc  = c ^ 3'($urandom_range(1, 7));
            tick(30);
            set_hall(gc);
            tick(len);
            set_hall(c);
            tick(dwell - 30 - len);
        end else begin
            tick(dwell);
        end
        chk("stepValid", m3stepValid, mvalid);
        if (mvalid) chk("stepFb", m3stepFb, mstep);
        chk("dirFb", m3dirFb, mdir);
        if (!mtrack)                       chk("stall", m3stall, 0);
        else if (acc && dwell > STALL + 50) chk("stall", m3stall, 1);
        else if (acc && dwell < STALL - 50) chk("stall", m3stall, 0);
    endtask

    task automatic check_zero();
        chk("rst_stepFb", m3stepFb, 0);
        chk("rst_stepValid", m3stepValid, 0);
        chk("rst_dirFb", m3dirFb, 0);
        chk("rst_periodFb", m3periodFb, 0);
        chk("rst_revPeriodFb", m3revPeriodFb, 0);
        chk("rst_strobes", {m3periodStb, m3revStb, m3hallErr, m3stall}, 0);
    endtask

    task automatic random_steps(int n);
        int s, r;
        logic [2:0] nc;
        for (int k = 0; k < n; k++) begin
            s = step_of(cur);
            r = $urandom_range(0, 99);
            if (r < 4)                 nc = ($urandom_range(0, 1) != 0) ? 3'b000 : 3'b111;
            else if (s < 0 || r >= 96) nc = lut[$urandom_range(0, 5)];
            else if (r < 70)           nc = lut[(s + 1) % 6];
            else if (r < 88)           nc = lut[(s + 5) % 6];
            else                       nc = lut[(s + $urandom_range(2, 4)) % 6];
            if (nc == cur) nc = (cur == 3'b101) ? 3'b100 : 3'b101;
            if ($urandom_range(0, 99) < 8) begin
                set_hall(nc);
                tick(4);
                set_hall(cur);
                tick(3);
            end
            apply(nc, $urandom_range(20, 250), $urandom_range(0, 99) < 30);
        end
    endtask

    initial begin
        model_reset();
        set_hall(3'b101);
        cur = 3'b101;
        tick(5);
        check_zero();
        rst = 1'b0;
        model_change(3'b101, cyc);
        tick(9);
        chk("init_latency_valid_low", m3stepValid, 0);
        tick(3);
        chk("init_valid", m3stepValid, 1);
        chk("init_step", m3stepFb, 0);
        tick(988);

        // Two forward revolutions, then on to step 3.
        for (int r = 0; r < 2; r++)
            for (int i = 1; i <= 6; i++) apply(lut[i % 6], 1000, 1'b0);
        apply(3'b100, 1000, 1'b0);
        apply(3'b110, 1000, 1'b0);
        apply(3'b010, 1000, 1'b0);
        // Reverse through step 0: direction change drops the revolution reference.
        apply(3'b110, 1000, 1'b0);
        apply(3'b100, 1000, 1'b0);
        apply(3'b101, 1000, 1'b0);
        apply(3'b001, 1000, 1'b0);
        // Illegal code, recovery, then a skip.
        apply(3'b000, 100, 1'b0);
        apply(3'b100, 100, 1'b0);
        apply(3'b101, 100, 1'b0);
        apply(3'b110, 100, 1'b0);
        apply(3'b010, 100, 1'b0);
        apply(3'b011, 100, 1'b0);
        // Stall, recovery, then a dwell exactly at the stall threshold.
        apply(3'b001, 6000, 1'b0);
        apply(3'b101, 200, 1'b0);
        apply(3'b100, STALL, 1'b0);
        apply(3'b110, 300, 1'b0);
        apply(3'b010, 300, 1'b0);
        // Dropout restarting the filter, and a short glitch inside a dwell.
        set_hall(3'b011);
        tick(4);
        set_hall(3'b010);
        tick(3);
        apply(3'b011, 300, 1'b0);
        apply(3'b001, 400, 1'b1);

        random_steps(150);

        chk("queue_drained_before_reset", expq.size(), 0);
        rst = 1'b1;
        tick(3);
        check_zero();
        rst = 1'b0;
        model_reset();
        if (cur != 3'b000) model_change(cur, cyc);
        tick(30);
        chk("post_reset_valid", m3stepValid, int'(mvalid));
        random_steps(12);

        tick(20);
        chk("queue_drained_at_end", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/motoro3_hall_decoder.md
Name: motoro3_hall_decoder

Overview:
- Feedback-side counterpart of the three-phase commutation driver.
- Samples the motor's three hall sensors and filters them.
- Decodes the 6-step electrical position and direction.
- Measures step period and electrical-revolution period in clk cycles, and flags stall and illegal hall sequences, for closed-loop speed control at 10 MHz.

Parameters:
- FILT_CYC, 8, consecutive identical synchronized samples required before a hall code is accepted (1..255).
- STALL_CYC, 10000000, step-period count at which stall is declared (1 s at 10 MHz); must fit 25 bits.

Ports:
- clk  input  1  system clock, 10 MHz.
- rst  input  1  synchronous reset, active-high.
- hallA  input  1  raw hall sensor A, asynchronous.
- hallB  input  1  raw hall sensor B, asynchronous.
- hallC  input  1  raw hall sensor C, asynchronous.
- m3stepFb  output  4  decoded step 0..5.
- m3stepValid  output  1  m3stepFb is meaningful.
- m3dirFb  output  1  1 = forward (step increments), 0 = reverse.
- m3periodFb  output  25  clk cycles between the last two legal adjacent steps.
- m3periodStb  output  1  one-cycle pulse when m3periodFb updates.
- m3revPeriodFb  output  25  clk cycles between the last two entries into step 0.
- m3revStb  output  1  one-cycle pulse when m3revPeriodFb updates.
- m3stall  output  1  level: no accepted edge for STALL_CYC cycles.
- m3hallErr  output  1  one-cycle pulse on illegal code or skipped step.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, synchronizers and filter cleared, counters 0, state INIT.
- Input path:
  - 2-flop synchronizer per hall line.
  - Filter counter: the synchronized code {A,B,C} becomes the filtered code only after FILT_CYC consecutive identical samples.
  - Latency from stable raw change to filtered change: 2+FILT_CYC cycles.
  - Any sample mismatch restarts the filter count.
- Code map (ABC -> step): 101->0, 100->1, 110->2, 010->3, 011->4, 001->5. 000 and 111 are illegal.
- Decode (combinational, on the filtered code): every transition rule below applies in the cycle the filtered code changes; the outputs it drives are registered and update on the next clk edge.
- stepCnt (25 bit): increments every cycle, saturating at STALL_CYC. Cleared to 0 on every accepted filtered change.
- revCnt (25 bit): increments every cycle, saturating at 2^25-1.
- State INIT (after reset or an illegal code):
  - First legal filtered code: load m3stepFb, m3stepValid=1, clear stepCnt and revCnt, no strobes, go TRACK.
  - Illegal code: stay in INIT.
- State TRACK, on filtered code change:
  - Legal, new = old+1 mod 6: m3dirFb=1.
  - Legal, new = old-1 mod 6: m3dirFb=0.
  - For either adjacent step: m3periodFb=stepCnt+1 and m3periodStb=1, unless m3stall is set or this is the first edge after a skip or INIT.
  - Legal, non-adjacent (delta ±2 or 3): m3hallErr=1, m3stepFb updated, m3dirFb held, no m3periodStb, revCnt reference invalidated.
  - Illegal code: m3hallErr=1, m3stepValid=0, m3stepFb held, go INIT, m3stall cleared.
  - stepCnt cleared on every accepted change.
- Stall:
  - When stepCnt reaches STALL_CYC: m3stall=1, stepCnt holds.
  - The next accepted legal edge clears m3stall; that edge's period is not published.
- Revolution:
  - On an adjacent edge entering step 0 with a valid reference: m3revPeriodFb=revCnt+1, m3revStb=1, revCnt=0.
  - Without a valid reference: revCnt=0, reference becomes valid, no strobe.
  - Reference is invalidated by INIT, skip, stall, or a direction change.
- Simultaneous events:
  - Stall threshold and accepted edge in the same cycle: edge wins, m3stall stays 0, period not published.
  - Strobes are never asserted for more than one cycle.
  - rst overrides everything mid-operation.

Test Plan:
- Reset, then hold ABC=101 stable -> after 2+8 cycles m3stepValid=1, m3stepFb=0, no strobes.
- Forward sequence 101,100,110,010,011,001 with 1000-cycle dwell:
  - From the second change on, m3periodStb pulses with m3periodFb=1000 and m3dirFb=1.
  - The second entry into step 0 gives m3revStb with m3revPeriodFb=6000.
- Glitch: 5-cycle pulse of 100 while at 101 (FILT_CYC=8) -> no step change, no strobes. A 3-cycle dropout within an otherwise stable 100 restarts the filter.
- Reverse at step 3 (010 -> 110) -> m3dirFb=0, m3stepFb=2, period published, next step-0 entry gives no m3revStb.
- Drive 000 from TRACK -> one-cycle m3hallErr, m3stepValid=0, state INIT; re-apply 100 -> m3stepValid=1, first edge after that publishes no period. Skip 101->110 -> m3hallErr, no m3periodStb.
- Hold code for STALL_CYC (bench override 5000) -> m3stall=1 at cycle 5000, stepCnt holds. Next adjacent edge clears m3stall with no m3periodStb. The following edge publishes a normal period.
